matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer_pkg.sv | 22 ++
 rtl/matmul_sequencer_skew_feeder.sv | 39 +++
 rtl/matmul_sequencer.sv | 142 ++++++++++++++
 tb/tb_matmul_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sequencer_pkg.sv
// Shared systolic definitions: sequencer state encoding, default geometry,
// and the operand element addressing used by both feed edges.
package matmul_sequencer_pkg;

  localparam int DW_DEF      = 8;
  localparam int BW_DEF      = 32;
  localparam int MAX_DIM_DEF = BW_DEF / DW_DEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Operand buses are row-major: one BW-wide word per row, DW per column.
  function automatic int elem_lsb(input int row, input int col, input int bw, input int dw);
    return row * bw + col * dw;
  endfunction

endpackage

// File: rtl/matmul_sequencer_skew_feeder.sv
// Diagonal skew for one array edge: lane s carries element index t-s at step t.
// Purely combinational from registered step/snapshot; IS_A selects row vs column lanes.
module skew_feeder
  import matmul_sequencer_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int BW      = BW_DEF,
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int DIMW    = $clog2(MAX_DIM),
  parameter int CW      = $clog2(3 * MAX_DIM),
  parameter bit IS_A    = 1'b1
) (
  input  logic [BW*MAX_DIM-1:0] op_i,
  input  logic [CW-1:0]         t_i,
  input  logic [DIMW-1:0]       lane_max_i,
  input  logic [DIMW-1:0]       k_max_i,
  input  logic                  en_i,
  output logic [DW*MAX_DIM-1:0] feed_o
);

  int idx;
  int lsb;

  always_comb begin
    feed_o = '0;
    idx    = 0;
    lsb    = 0;
    if (en_i) begin
      for (int s = 0; s < MAX_DIM; s++) begin
        idx = int'(t_i) - s;
        if (s <= int'(lane_max_i) && idx >= 0 && idx <= int'(k_max_i)) begin
          lsb = IS_A ? elem_lsb(s, idx, BW, DW) : elem_lsb(idx, s, BW, DW);
          feed_o[s*DW +: DW] = op_i[lsb +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Systolic matmul feed sequencer: clear, skewed feed for N+K+M-2 steps, drain, done.
// Operands and dims are snapshotted at start; dropping start before DONE aborts silently.
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int BW      = BW_DEF,
  parameter int MAX_DIM = BW / DW,
  parameter int PE_LAT  = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        start_i,
  input  logic [$clog2(MAX_DIM)-1:0]  n_dim_i,
  input  logic [$clog2(MAX_DIM)-1:0]  k_dim_i,
  input  logic [$clog2(MAX_DIM)-1:0]  m_dim_i,
  input  logic [BW*MAX_DIM-1:0]       operand_a_i,
  input  logic [BW*MAX_DIM-1:0]       operand_b_i,
  output logic [DW*MAX_DIM-1:0]       a_feed_o,
  output logic [DW*MAX_DIM-1:0]       b_feed_o,
  output logic                        feed_valid_o,
  output logic                        pe_clear_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int DIMW = $clog2(MAX_DIM);
  localparam int CW   = $clog2(3 * MAX_DIM);

  state_e                state_q, state_d;
  logic [CW-1:0]         t_q, t_d;
  logic [BW*MAX_DIM-1:0] a_q, a_d, b_q, b_d;
  logic [DIMW-1:0]       n_q, n_d, k_q, k_d, m_q, m_d;
  logic                  last_feed;

  // Last step index is T-1 = (N-1)+(K-1)+(M-1).
  assign last_feed = (t_q == CW'(n_q) + CW'(k_q) + CW'(m_q));

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    k_d     = k_q;
    m_d     = m_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CLEAR;
          t_d     = '0;
          a_d     = operand_a_i;
          b_d     = operand_b_i;
          n_d     = n_dim_i;
          k_d     = k_dim_i;
          m_d     = m_dim_i;
        end
      end
      ST_CLEAR: begin
        state_d = start_i ? ST_FEED : ST_IDLE;
        t_d     = '0;
      end
      ST_FEED: begin
        if (!start_i) begin
          state_d = ST_IDLE;
          t_d     = '0;
        end else if (last_feed) begin
          state_d = ST_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!start_i) begin
          state_d = ST_IDLE;
          t_d     = '0;
        end else if (t_q == CW'(PE_LAT - 1)) begin
          state_d = ST_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!start_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      k_q     <= k_d;
      m_q     <= m_d;
    end
  end

  assign feed_valid_o = (state_q == ST_FEED);
  assign pe_clear_o   = (state_q == ST_CLEAR);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);

  skew_feeder #(
    .DW(DW), .BW(BW), .MAX_DIM(MAX_DIM), .DIMW(DIMW), .CW(CW), .IS_A(1'b1)
  ) u_feed_a (
    .op_i       (a_q),
    .t_i        (t_q),
    .lane_max_i (n_q),
    .k_max_i    (k_q),
    .en_i       (feed_valid_o),
    .feed_o     (a_feed_o)
  );

  skew_feeder #(
    .DW(DW), .BW(BW), .MAX_DIM(MAX_DIM), .DIMW(DIMW), .CW(CW), .IS_A(1'b0)
  ) u_feed_b (
    .op_i       (b_q),
    .t_i        (t_q),
    .lane_max_i (m_q),
    .k_max_i    (k_q),
    .en_i       (feed_valid_o),
    .feed_o     (b_feed_o)
  );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a small systolic PE reference model.
module tb_matmul_sequencer;

  localparam int DW = 8;
  localparam int BW = 32;
  localparam int MD = 4;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic            start_i;
  logic [1:0]      n_dim_i, k_dim_i, m_dim_i;
  logic [BW*MD-1:0] operand_a_i, operand_b_i;
  logic [DW*MD-1:0] a_feed_o, b_feed_o;
  logic            feed_valid_o, pe_clear_o, busy_o, done_o;

  int tests = 0;
  int fails = 0;

  // observation record filled by run_obs
  int clear_cyc, first_feed, feed_cnt, done_cyc, bad_idle;
  logic [DW*MD-1:0] a_hist [12];
  logic [DW*MD-1:0] b_hist [12];

  // systolic reference model
  int c_m [MD][MD];
  int a_r [MD][MD];
  int b_r [MD][MD];

  matmul_sequencer #(.DW(DW), .BW(BW), .MAX_DIM(MD), .PE_LAT(1)) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .start_i      (start_i),
    .n_dim_i      (n_dim_i),
    .k_dim_i      (k_dim_i),
    .m_dim_i      (m_dim_i),
    .operand_a_i  (operand_a_i),
    .operand_b_i  (operand_b_i),
    .a_feed_o     (a_feed_o),
    .b_feed_o     (b_feed_o),
    .feed_valid_o (feed_valid_o),
    .pe_clear_o   (pe_clear_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Outputs seen now are consumed by the PE array on the next edge.
  task automatic model_step;
    int na [MD][MD];
    int nb [MD][MD];
    int ai, bi;
    if (pe_clear_o) begin
      for (int i = 0; i < MD; i++)
        for (int j = 0; j < MD; j++) begin
          c_m[i][j] = 0; a_r[i][j] = 0; b_r[i][j] = 0;
        end
    end
    if (feed_valid_o) begin
      for (int i = 0; i < MD; i++)
        for (int j = 0; j < MD; j++) begin
          ai = (j == 0) ? int'(a_feed_o[i*DW +: DW]) : a_r[i][j-1];
          bi = (i == 0) ? int'(b_feed_o[j*DW +: DW]) : b_r[i-1][j];
          c_m[i][j] += ai * bi;
          na[i][j] = ai;
          nb[i][j] = bi;
        end
      a_r = na;
      b_r = nb;
    end
  endtask

  // Runs ncyc edges (start assumed raised just before edge 1); optionally
  // overwrites operand_a_i with all-ones after cycle chg_at.
  task automatic run_obs(input int ncyc, input int chg_at);
    clear_cyc = -1; first_feed = -1; feed_cnt = 0; done_cyc = -1; bad_idle = 0;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (pe_clear_o && clear_cyc < 0) clear_cyc = c;
      if (feed_valid_o) begin
        if (first_feed < 0) first_feed = c;
        if (feed_cnt < 12) begin
          a_hist[feed_cnt] = a_feed_o;
          b_hist[feed_cnt] = b_feed_o;
        end
        feed_cnt++;
      end else if (a_feed_o !== '0 || b_feed_o !== '0) begin
        bad_idle++;
      end
      if (done_o && done_cyc < 0) done_cyc = c;
      model_step();
      if (c == chg_at) operand_a_i = '1;
    end
  endtask

  task automatic load_4x4_ident;
    operand_a_i = '0;
    operand_b_i = '0;
    for (int i = 0; i < MD; i++) begin
      operand_a_i[i*BW + i*DW +: DW] = 8'd1;
      for (int j = 0; j < MD; j++)
        operand_b_i[i*BW + j*DW +: DW] = 8'(4*i + j + 1);
    end
    n_dim_i = 2'd3; k_dim_i = 2'd3; m_dim_i = 2'd3;
  endtask

  task automatic check_c_eq_b(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++)
        if (c_m[i][j] !== 4*i + j + 1) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d C elements differ from B (C[0][0]=%0d C[3][3]=%0d, need 1 and 16)",
               name, bad, c_m[0][0], c_m[3][3]);
    end
  endtask

  task automatic test_reset;
    reset_ni = 1'b0; start_i = 1'b0;
    n_dim_i = '0; k_dim_i = '0; m_dim_i = '0;
    operand_a_i = '0; operand_b_i = '0;
    #23;
    tests++;
    if ({busy_o, done_o, feed_valid_o, pe_clear_o} !== 4'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b need 0000", {busy_o, done_o, feed_valid_o, pe_clear_o});
    end
    tests++;
    if (a_feed_o !== '0 || b_feed_o !== '0) begin
      fails++; $display("FAIL reset_feeds: a=%h b=%h need 0", a_feed_o, b_feed_o);
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
    tests++;
    if (busy_o !== 1'b0) begin
      fails++; $display("FAIL idle_no_start: busy=%b need 0", busy_o);
    end
  endtask

  task automatic test_4x4;
    load_4x4_ident();
    start_i = 1'b1;
    run_obs(14, 0);
    tests++;
    if (clear_cyc !== 1) begin fails++; $display("FAIL 4x4_clear_cyc: got %0d need 1", clear_cyc); end
    tests++;
    if (first_feed !== 2) begin fails++; $display("FAIL 4x4_first_feed: got %0d need 2", first_feed); end
    tests++;
    if (feed_cnt !== 10) begin fails++; $display("FAIL 4x4_feed_cnt: got %0d need 10", feed_cnt); end
    tests++;
    if (done_cyc !== 13) begin fails++; $display("FAIL 4x4_done_cyc: got %0d need 13", done_cyc); end
    tests++;
    if (bad_idle !== 0) begin fails++; $display("FAIL 4x4_idle_feeds: got %0d nonzero cycles need 0", bad_idle); end
    check_c_eq_b("4x4_result");
  endtask

  task automatic test_done_hold;
    int low;
    low = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done_o !== 1'b1 || busy_o !== 1'b1) low++;
    end
    tests++;
    if (low !== 0) begin fails++; $display("FAIL done_hold: %0d cycles without done need 0", low); end
    start_i = 1'b0;
    tick();
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL done_release: done=%b busy=%b need 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_2x2;
    logic [DW*MD-1:0] ea [4];
    logic [DW*MD-1:0] eb [4];
    int bad;
    // A=[[1,2],[3,4]] B=[[5,6],[7,8]]; slots packed {s3,s2,s1,s0}
    operand_a_i = '0; operand_b_i = '0;
    operand_a_i[0*BW + 0 +: 8] = 8'd1; operand_a_i[0*BW + 8 +: 8] = 8'd2;
    operand_a_i[1*BW + 0 +: 8] = 8'd3; operand_a_i[1*BW + 8 +: 8] = 8'd4;
    operand_b_i[0*BW + 0 +: 8] = 8'd5; operand_b_i[0*BW + 8 +: 8] = 8'd6;
    operand_b_i[1*BW + 0 +: 8] = 8'd7; operand_b_i[1*BW + 8 +: 8] = 8'd8;
    // junk outside the 2x2 window must never reach the feeds
    operand_a_i[2*BW + 0 +: 8] = 8'hAA; operand_a_i[0*BW + 16 +: 8] = 8'hBB;
    operand_b_i[0*BW + 16 +: 8] = 8'hCC; operand_b_i[2*BW + 0 +: 8] = 8'hDD;
    n_dim_i = 2'd1; k_dim_i = 2'd1; m_dim_i = 2'd1;
    ea[0] = 32'h0000_0001; ea[1] = 32'h0000_0302; ea[2] = 32'h0000_0400; ea[3] = 32'h0;
    eb[0] = 32'h0000_0005; eb[1] = 32'h0000_0607; eb[2] = 32'h0000_0800; eb[3] = 32'h0;
    start_i = 1'b1;
    run_obs(8, 0);
    tests++;
    if (feed_cnt !== 4) begin fails++; $display("FAIL 2x2_feed_cnt: got %0d need 4", feed_cnt); end
    tests++;
    if (done_cyc !== 7) begin fails++; $display("FAIL 2x2_done_cyc: got %0d need 7", done_cyc); end
    bad = 0;
    for (int t = 0; t < 4; t++) begin
      if (a_hist[t] !== ea[t]) begin
        bad++; $display("FAIL 2x2_a_feed step %0d: got %h need %h", t, a_hist[t], ea[t]);
      end
      if (b_hist[t] !== eb[t]) begin
        bad++; $display("FAIL 2x2_b_feed step %0d: got %h need %h", t, b_hist[t], eb[t]);
      end
    end
    tests++;
    if (bad !== 0) fails++;
    tests++;
    if (c_m[0][0] !== 19 || c_m[0][1] !== 22 || c_m[1][0] !== 43 || c_m[1][1] !== 50) begin
      fails++;
      $display("FAIL 2x2_result: got %0d %0d %0d %0d need 19 22 43 50",
               c_m[0][0], c_m[0][1], c_m[1][0], c_m[1][1]);
    end
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_snapshot;
    load_4x4_ident();
    start_i = 1'b1;
    run_obs(14, 5);
    tests++;
    if (done_cyc !== 13) begin fails++; $display("FAIL snap_done_cyc: got %0d need 13", done_cyc); end
    check_c_eq_b("snap_result");
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    int seen_done, reached;
    load_4x4_ident();
    seen_done = 0; reached = 0; feed_cnt = 0;
    start_i = 1'b1;
    for (int c = 0; c < 20 && !reached; c++) begin
      tick();
      if (done_o) seen_done++;
      if (feed_valid_o) feed_cnt++;
      if (feed_cnt == 4) reached = 1;  // showing step 3
    end
    tests++;
    if (!reached) begin fails++; $display("FAIL abort_reach_step3: got feed count %0d need 4", feed_cnt); end
    start_i = 1'b0;
    tick();
    if (done_o) seen_done++;
    tests++;
    if (busy_o !== 1'b0 || feed_valid_o !== 1'b0) begin
      fails++; $display("FAIL abort_idle: busy=%b feed_valid=%b need 0 0", busy_o, feed_valid_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done_o) seen_done++;
    end
    tests++;
    if (seen_done !== 0) begin fails++; $display("FAIL abort_no_done: got %0d done cycles need 0", seen_done); end
    start_i = 1'b1;
    tick();
    tests++;
    if (pe_clear_o !== 1'b1 || busy_o !== 1'b1) begin
      fails++; $display("FAIL relaunch: pe_clear=%b busy=%b need 1 1", pe_clear_o, busy_o);
    end
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int reached;
    load_4x4_ident();
    reached = 0; feed_cnt = 0;
    start_i = 1'b1;
    for (int c = 0; c < 20 && !reached; c++) begin
      tick();
      if (feed_valid_o) feed_cnt++;
      if (feed_cnt == 6) reached = 1;  // showing step 5
    end
    tests++;
    if (!reached) begin fails++; $display("FAIL rst_reach_step5: got feed count %0d need 6", feed_cnt); end
    reset_ni = 1'b0;
    #1;
    tests++;
    if ({busy_o, done_o, feed_valid_o, pe_clear_o} !== 4'b0 || a_feed_o !== '0 || b_feed_o !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: ctrl=%b a=%h b=%h need all 0",
               {busy_o, done_o, feed_valid_o, pe_clear_o}, a_feed_o, b_feed_o);
    end
    start_i = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
    start_i = 1'b1;
    run_obs(14, 0);
    tests++;
    if (clear_cyc !== 1 || first_feed !== 2 || feed_cnt !== 10 || done_cyc !== 13) begin
      fails++;
      $display("FAIL rst_rerun_timing: clear=%0d feed0=%0d cnt=%0d done=%0d need 1 2 10 13",
               clear_cyc, first_feed, feed_cnt, done_cyc);
    end
    check_c_eq_b("rst_rerun_result");
    start_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_4x4();
    test_done_hold();
    test_2x2();
    test_snapshot();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
